dbus_arbiter: RTL and testbench

DBUS_ARBITER -- requirements
Module: dbus_arbiter

---
 rtl/dbus_pkg.sv | 18 +
 rtl/dbus_arbiter_rr_pick.sv | 31 +++
 rtl/dbus_arbiter.sv | 126 ++++++++++++
 tb/tb_dbus_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared DBus definitions: arbiter state encoding, default sizing and small helpers.
// Used by dbus_arbiter and later DBus blocks.
package dbus_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    localparam int DBUS_NUM_MASTERS = 4;
    localparam int DBUS_MAX_HOLD    = 16;
    localparam int DBUS_HOLD_W      = 8;

    // Successor of a master index with wrap-around; used to advance the round-robin pointer.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above the
// pointer, searching upward with wrap-around.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_Req,
    input  logic [W-1:0] i_Ptr,
    output logic         o_Valid,
    output logic [W-1:0] o_Idx
);

    int j;

    // Scan from the farthest offset down so the closest requester is written last and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        o_Valid = 1'b0;
        o_Idx   = '0;
        j       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(i_Ptr) + i;
            if (j >= N) j = j - N;
            if (i_Req[j]) begin
                o_Valid = 1'b1;
                o_Idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter for the shared tri-state DBus with hold limit, lock and turnaround.
// Optional master-0 bus parking is enabled by defining DBUS_ARB_PARK_EN.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int NUM_MASTERS = DBUS_NUM_MASTERS,
    parameter int MAX_HOLD    = DBUS_MAX_HOLD
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst_n,
    input  logic [NUM_MASTERS-1:0]         i_Req,
    input  logic [NUM_MASTERS-1:0]         i_Lock,
    output logic [NUM_MASTERS-1:0]         o_Gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] o_GntId,
    output logic                           o_BusIdle
);

    localparam int ID_W = $clog2(NUM_MASTERS);
    localparam logic [DBUS_HOLD_W-1:0] HOLD_LIMIT = DBUS_HOLD_W'(MAX_HOLD - 1);

`ifdef DBUS_ARB_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif
    localparam logic [NUM_MASTERS-1:0] IDLE_GNT = PARK_EN ? NUM_MASTERS'(1) : '0;

    logic [1:0]             state,    state_d;
    logic [NUM_MASTERS-1:0] gnt,      gnt_d;
    logic [ID_W-1:0]        gnt_id,   gnt_id_d;
    logic [ID_W-1:0]        ptr,      ptr_d;
    logic [DBUS_HOLD_W-1:0] hold_cnt, hold_d;
    logic                   arb_en;

    logic                   pick_valid;
    logic [ID_W-1:0]        pick_idx;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   others_req;
    logic                   hold_expired;

    rr_pick #(.N(NUM_MASTERS), .W(ID_W)) u_rr_pick (
        .i_Req   (i_Req),
        .i_Ptr   (ptr),
        .o_Valid (pick_valid),
        .o_Idx   (pick_idx)
    );

    assign owner_req    = |(i_Req & gnt);
    assign owner_lock   = |(i_Lock & gnt);
    assign others_req   = |(i_Req & ~gnt);
    assign hold_expired = (hold_cnt >= HOLD_LIMIT);

    always_comb begin
        state_d  = state;
        gnt_d    = gnt;
        gnt_id_d = gnt_id;
        ptr_d    = ptr;
        hold_d   = hold_cnt;
        case (state)
            IDLE, TURN: begin
                if (!pick_valid) begin
                    state_d  = IDLE;
                    gnt_d    = IDLE_GNT;
                    gnt_id_d = '0;
                    hold_d   = '0;
                end else if (PARK_EN && state == IDLE && pick_idx != '0) begin
                    // Parked master 0 must release the bus for a turnaround cycle first.
                    state_d  = TURN;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end else begin
                    state_d         = GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_id_d        = pick_idx;
                    ptr_d           = ID_W'(rr_next(int'(pick_idx), NUM_MASTERS));
                    hold_d          = '0;
                end
            end
            GRANT: begin
                if (!owner_req || (hold_expired && others_req && !owner_lock)) begin
                    state_d  = TURN;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    hold_d   = '0;
                end else if (!hold_expired) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = IDLE_GNT;
                gnt_id_d = '0;
                hold_d   = '0;
            end
        endcase
    end

    // arb_en holds off arbitration for the first edge after reset release.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            arb_en   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
            arb_en <= 1'b1;
            if (arb_en) begin
                state    <= state_d;
                gnt      <= gnt_d;
                gnt_id   <= gnt_id_d;
                ptr      <= ptr_d;
                hold_cnt <= hold_d;
            end
        end
    end

    assign o_Gnt     = gnt;
    assign o_GntId   = gnt_id;
    assign o_BusIdle = ~|gnt;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter (4 masters, hold limit 4): vector table plus
// multi-cycle sequences for rotation, lock, and reset mid-grant.
module tb_dbus_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] gnt;
        logic [1:0]   id;
        logic         idle;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         bus_idle;

    int total;
    int bad;
    vec_t vecs[$];

    dbus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_Req     (req),
        .i_Lock    (lock),
        .o_Gnt     (gnt),
        .o_GntId   (gnt_id),
        .o_BusIdle (bus_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [N-1:0] g, input logic [1:0] id,
                             input logic idle);
        check({name, ".gnt"}, int'(gnt), int'(g));
        check({name, ".id"}, int'(gnt_id), int'(id));
        check({name, ".idle"}, int'(bus_idle), int'(idle));
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l);
        req  = r;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N-1:0] g, input logic [1:0] id);
        vec_t x;
        x.req  = r;
        x.lock = l;
        x.gnt  = g;
        x.id   = id;
        x.idle = (g == '0);
        return x;
    endfunction

    // One-hot-or-zero grant monitor for the whole run.
    always @(negedge clk) begin
        total++;
        if (!$onehot0(gnt)) begin
            bad++;
            $display("FAIL onehot0: got %b, want one-hot or zero (t=%0t)", gnt, $time);
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        req   = '0;
        lock  = '0;
        rst_n = 1'b0;
        #1;
        check_out("reset", 4'b0000, 2'd0, 1'b1);
        #11;
        rst_n = 1'b1;

`ifdef DBUS_ARB_PARK_EN
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 2'd0)); // first edge: arbitration held off
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0001, 2'd0)); // parked on master 0
        vecs.push_back(v(4'b0001, 4'b0000, 4'b0001, 2'd0)); // master 0: no zero cycle
        vecs.push_back(v(4'b0001, 4'b0000, 4'b0001, 2'd0));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 2'd0)); // release -> TURN
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0001, 2'd0)); // parked again
        vecs.push_back(v(4'b1000, 4'b0000, 4'b0000, 2'd0)); // master 3 -> TURN first
        vecs.push_back(v(4'b1000, 4'b0000, 4'b1000, 2'd3));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 2'd0));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0001, 2'd0));
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].lock);
            check_out($sformatf("park[%0d]", i), vecs[i].gnt, vecs[i].id, vecs[i].idle);
        end
`else
        vecs.push_back(v(4'b0100, 4'b0000, 4'b0000, 2'd0)); // first edge after release: no grant
        vecs.push_back(v(4'b0100, 4'b0000, 4'b0100, 2'd2));
        vecs.push_back(v(4'b0100, 4'b0000, 4'b0100, 2'd2));
        vecs.push_back(v(4'b0100, 4'b0000, 4'b0100, 2'd2));
        vecs.push_back(v(4'b0100, 4'b0000, 4'b0100, 2'd2)); // hold saturates, nobody waiting
        vecs.push_back(v(4'b0100, 4'b0000, 4'b0100, 2'd2));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 2'd0)); // TURN
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 2'd0)); // IDLE
        vecs.push_back(v(4'b0001, 4'b0000, 4'b0001, 2'd0)); // ptr 3 wraps to 0
        vecs.push_back(v(4'b0011, 4'b0000, 4'b0001, 2'd0));
        vecs.push_back(v(4'b0011, 4'b0000, 4'b0001, 2'd0));
        vecs.push_back(v(4'b0011, 4'b0000, 4'b0001, 2'd0));
        vecs.push_back(v(4'b0011, 4'b0000, 4'b0000, 2'd0)); // hold limit -> revoke
        vecs.push_back(v(4'b0011, 4'b0000, 4'b0010, 2'd1));
        vecs.push_back(v(4'b0001, 4'b0000, 4'b0000, 2'd0)); // owner drops
        vecs.push_back(v(4'b0011, 4'b0000, 4'b0001, 2'd0)); // master 1 re-requests: lowest priority
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 2'd0));
        vecs.push_back(v(4'b1000, 4'b0000, 4'b1000, 2'd3)); // grant straight out of TURN
        vecs.push_back(v(4'b1000, 4'b1000, 4'b1000, 2'd3));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 2'd0));
        vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 2'd0));
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].lock);
            check_out($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].id, vecs[i].idle);
        end

        // All masters requesting: 4-cycle tenures, one zero cycle between, order 0,1,2,3,...
        for (int c = 0; c < 40; c++) begin
            logic [N-1:0] exp_g;
            exp_g = ((c % 5) < 4) ? N'(1 << ((c / 5) % 4)) : '0;
            step(4'b1111, 4'b0000);
            check($sformatf("rotate[%0d]", c), int'(gnt), int'(exp_g));
        end
        step(4'b0000, 4'b0000);
        check_out("rotate_end", 4'b0000, 2'd0, 1'b1);

        // Locked owner outlasts the hold limit; revocation follows the lock release.
        step(4'b0010, 4'b0010);
        check_out("lock_grant", 4'b0010, 2'd1, 1'b0);
        for (int c = 0; c < 30; c++) begin
            step(4'b1010, 4'b0010);
            check($sformatf("lock_hold[%0d]", c), int'(gnt), 4'b0010);
        end
        step(4'b1010, 4'b0000);
        check_out("lock_revoke", 4'b0000, 2'd0, 1'b1);
        step(4'b1010, 4'b0000);
        check_out("lock_next", 4'b1000, 2'd3, 1'b0);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        check_out("lock_idle", 4'b0000, 2'd0, 1'b1);

        // Reset pulsed between edges while master 2 owns the bus.
        step(4'b0100, 4'b0000);
        check_out("rst_pre", 4'b0100, 2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 4'b0000, 2'd0, 1'b1);
        #2;
        rst_n = 1'b1;
        step(4'b0100, 4'b0000);
        check_out("rst_edge1", 4'b0000, 2'd0, 1'b1);
        step(4'b0100, 4'b0000);
        check_out("rst_edge2", 4'b0100, 2'd2, 1'b0);
`endif

        step(4'b0000, 4'b0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
